// File: rtl/vedic_mul_seq16.sv
// Sequential 16x16 unsigned multiplier: one combinational 8x8 vedic core is
// time-shared over the four byte partial products, accumulated in four cycles.
module vedic_mul_seq16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] p,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  step_q, step_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [31:0] acc_q, acc_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic        busy_q, busy_d;

   logic [7:0]  op_x_s, op_y_s;
   logic [15:0] pp_s;
   logic [31:0] pp_shift_s;

   function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
      logic c;
      c = x[1] & y[0] & x[0] & y[1];
      vedic2 = {x[1] & y[1] & c, (x[1] & y[1]) ^ c, (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
   endfunction

   function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
      logic [3:0] q0, q1, q2, q3;
      q0 = vedic2(x[1:0], y[1:0]);
      q1 = vedic2(x[3:2], y[1:0]);
      q2 = vedic2(x[1:0], y[3:2]);
      q3 = vedic2(x[3:2], y[3:2]);
      vedic4 = {q3, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00};
   endfunction

   function automatic logic [15:0] vedic8(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] q0, q1, q2, q3;
      q0 = vedic4(x[3:0], y[3:0]);
      q1 = vedic4(x[7:4], y[3:0]);
      q2 = vedic4(x[3:0], y[7:4]);
      q3 = vedic4(x[7:4], y[7:4]);
      vedic8 = {q3, q0} + {4'h0, q1, 4'h0} + {4'h0, q2, 4'h0};
   endfunction

   // Byte select and alignment of the partial product for the current step
   always_comb begin
      op_x_s = step_q[0] ? a_q[15:8] : a_q[7:0];
      op_y_s = step_q[1] ? b_q[15:8] : b_q[7:0];
      pp_s   = vedic8(op_x_s, op_y_s);
      case (step_q)
         2'd0:    pp_shift_s = {16'h0000, pp_s};
         2'd1:    pp_shift_s = {8'h00, pp_s, 8'h00};
         2'd2:    pp_shift_s = {8'h00, pp_s, 8'h00};
         2'd3:    pp_shift_s = {pp_s, 16'h0000};
         default: pp_shift_s = {16'h0000, pp_s};
      endcase
   end

   // Next-state and datapath update logic
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = CALC;
               a_d     = a;
               b_d     = b;
               acc_d   = 32'h0000_0000;
               step_d  = 2'd0;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            acc_d  = acc_q + pp_shift_s;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
               state_d = DONE;
            end else begin
               state_d = CALC;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // State, operand, accumulator and output flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         step_q      <= 2'd0;
         a_q         <= 16'h0000;
         b_q         <= 16'h0000;
         acc_q       <= 32'h0000_0000;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign p         = acc_q;

endmodule

// File: tb/tb_vedic_mul_seq16.sv
// Scoreboard bench: expected products are queued at accept and checked by a
// negedge monitor; directed tasks add latency, back-pressure and reset checks.
module tb_vedic_mul_seq16;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] p;
   logic        busy;

   int          total = 0;
   int          bad = 0;
   bit          mon_en = 1'b0;
   bit          rnd_done = 1'b0;
   logic [31:0] sb_q[$];
   int          age = 0;

   vedic_mul_seq16 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
      ref_mul = 32'(x) * 32'(y);
   endfunction

   // Monitor: model says IDLE iff nothing outstanding; product due 4 edges after accept
   always @(negedge clk) begin
      if (mon_en) begin
         bit idle_m;
         bit exp_v;
         idle_m = (sb_q.size() == 0);
         if (!idle_m) age++;
         exp_v = !idle_m && (age >= 5);
         chk("mon_in_ready", 32'(in_ready), 32'(idle_m));
         chk("mon_busy", 32'(busy), 32'(!idle_m));
         chk("mon_out_valid", 32'(out_valid), 32'(exp_v));
         if (exp_v) chk("mon_p", p, sb_q[0]);
         if (rst) begin
            sb_q.delete();
            age = 0;
         end else begin
            if (exp_v && out_ready) void'(sb_q.pop_front());
            if (idle_m && in_valid) begin
               sb_q.push_back(ref_mul(a, b));
               age = 0;
            end
         end
      end
   end

   // Drive an operand pair until accepted; returns at accept edge + 1
   task automatic issue(input logic [15:0] ia, input logic [15:0] ib);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      a = ia;
      b = ib;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (n < 20 && !out_valid) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic cycle;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      logic [15:0] ra, rb;
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [15:0] ra, rb;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = 16'h0000;
      b = 16'h0000;
      repeat (3) cycle();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_p", p, 32'h0000_0000);
      rst = 1'b0;
      mon_en = 1'b1;
      cycle();

      // basic product
      out_ready = 1'b1;
      issue(16'h1234, 16'h5678);
      in_valid = 1'b0;
      a = 16'hDEAD;
      b = 16'hBEEF;
      wait_out(n);
      chk("basic_latency", 32'(n), 32'd4);
      chk("basic_p", p, 32'h0626_0060);
      cycle();
      chk("basic_in_ready", 32'(in_ready), 32'd1);
      chk("basic_out_valid_low", 32'(out_valid), 32'd0);

      // corners
      issue(16'hFFFF, 16'hFFFF);
      in_valid = 1'b0;
      wait_out(n);
      chk("ffff_latency", 32'(n), 32'd4);
      chk("ffff_p", p, 32'hFFFE_0001);
      cycle();
      issue(16'h0000, 16'hABCD);
      in_valid = 1'b0;
      wait_out(n);
      chk("zero_latency", 32'(n), 32'd4);
      chk("zero_p", p, 32'h0000_0000);
      cycle();

      // back-pressure
      out_ready = 1'b0;
      issue(16'h00FF, 16'h0100);
      in_valid = 1'b0;
      wait_out(n);
      chk("bp_latency", 32'(n), 32'd4);
      for (int k = 0; k < 3; k++) begin
         chk("bp_p", p, 32'h0000_FF00);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         if (k < 2) cycle();
      end
      out_ready = 1'b1;
      cycle();
      chk("bp_done_valid", 32'(out_valid), 32'd0);
      chk("bp_done_ready", 32'(in_ready), 32'd1);

      // operand isolation with a held request
      ra = 16'hA5C3;
      rb = 16'h3C5A;
      issue(16'h4321, 16'h8765);
      a = ra;
      b = rb;
      chk("iso_no_ready", 32'(in_ready), 32'd0);
      wait_out(n);
      chk("iso_latency", 32'(n), 32'd4);
      chk("iso_p1", p, ref_mul(16'h4321, 16'h8765));
      cycle();
      chk("iso_idle", 32'(in_ready), 32'd1);
      cycle();
      in_valid = 1'b0;
      chk("iso_accepted", 32'(busy), 32'd1);
      wait_out(n);
      chk("iso_latency2", 32'(n), 32'd4);
      chk("iso_p2", p, ref_mul(ra, rb));
      cycle();

      // reset on the edge after step1
      issue(16'h7777, 16'h9999);
      in_valid = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_p", p, 32'h0000_0000);
      repeat (8) cycle();

      // randomised back-to-back run
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               repeat ($urandom_range(0, 2)) cycle();
               case ($urandom_range(0, 7))
                  0: ra = 16'h0000;
                  1: ra = 16'hFFFF;
                  default: ra = 16'($urandom);
               endcase
               case ($urandom_range(0, 7))
                  0: rb = 16'h0000;
                  1: rb = 16'hFFFF;
                  default: rb = 16'($urandom);
               endcase
               issue(ra, rb);
               in_valid = 1'b0;
               a = 16'($urandom);
               b = 16'($urandom);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               cycle();
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      for (int k = 0; k < 20 && sb_q.size() != 0; k++) cycle();
      chk("drain_empty", 32'(sb_q.size()), 32'd0);
      repeat (3) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vedic_mul_seq16.md
VEDIC_MUL_SEQ16 -- requirements
Module: vedic_mul_seq16

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 16 bits and product width at 32 bits.
REQ-002 The block SHALL use one clock and a synchronous active-high reset.
REQ-003 Port list:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  16  multiplicand.
- b  input  16  multiplier.
- out_valid  output  1  p holds a completed product.
- out_ready  input  1  consumer accepts p.
- p  output  32  product a*b, unsigned.
- busy  output  1  state is not IDLE.

Function
REQ-004 The block SHALL compute the unsigned 32-bit product by time-sharing one combinational 8x8 vedic core (16-bit result) over four partial products.
REQ-005 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
- IDLE -> CALC on the accept edge.
- CALC -> DONE after step 3.
- DONE -> IDLE on out_ready.
REQ-006 in_ready SHALL equal 1 only in IDLE, and an accept SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-007 On accept, the block SHALL register a and b into internal operand registers, clear the 32-bit accumulator and set the 2-bit step counter to 0.
REQ-008 Changes on a/b after accept SHALL NOT affect the result.
REQ-009 In CALC, each rising edge SHALL add one partial product to the accumulator and increment step:
- step0: a_lo*b_lo, shifted by 0.
- step1: a_hi*b_lo, shifted by 8.
- step2: a_lo*b_hi, shifted by 8.
- step3: a_hi*b_hi, shifted by 16.
REQ-010 Accumulation SHALL be 32-bit modulo 2^32; no overflow can occur for exact products.
REQ-011 The edge that adds step3 SHALL move the FSM to DONE and set out_valid=1.
REQ-012 Latency SHALL be 4 clock edges: if accept is edge E0, out_valid is first high after edge E4.
REQ-013 p SHALL be driven directly from the accumulator register.
REQ-014 p SHALL be stable and out_valid SHALL remain 1 for as long as out_ready=0 in DONE.
REQ-015 An edge in DONE with out_ready=1 SHALL complete the transfer: out_valid goes to 0 and the state returns to IDLE.
REQ-016 A new accept SHALL NOT occur on the same edge as a transfer, giving a minimum initiation interval of 6 cycles.
REQ-017 in_valid asserted during CALC or DONE SHALL be ignored; the pending request stays unaccepted until in_ready=1.
REQ-018 out_ready asserted outside DONE SHALL have no effect.
REQ-019 busy SHALL equal 1 in CALC and DONE, and 0 in IDLE.
REQ-020 Operands of 0 SHALL still take the full 4-cycle sequence, with no early termination.

Reset
REQ-021 On any rising edge with rst=1, the block SHALL go to IDLE regardless of state, including mid-CALC and in DONE.
REQ-022 Reset values SHALL be:
- in_ready = 1.
- out_valid = 0.
- busy = 0.
- p = 0x00000000.
- step counter = 0.
- operand registers = 0.
REQ-023 rst SHALL take priority over in_valid and out_ready on the same edge.
REQ-024 Any in-flight computation SHALL be discarded by reset and SHALL NOT produce an out_valid.

Verification
REQ-025 Basic product:
- Stimulus: a=0x1234, b=0x5678, in_valid for one cycle, out_ready=1.
- Response: out_valid high exactly 4 edges after accept with p=0x06260060, then IDLE with in_ready=1.
REQ-026 Corner operands:
- Stimulus: a=0xFFFF, b=0xFFFF.
- Response: p=0xFFFE0001.
- Stimulus: a=0x0000, b=0xABCD.
- Response: p=0x00000000 after the full 4-edge latency.
REQ-027 Back-pressure:
- Stimulus: out_ready=0 for 3 cycles after out_valid rises, with a=0x00FF, b=0x0100.
- Response: p holds 0x0000FF00 with out_valid=1 and in_ready=0 throughout; the transfer completes on the first edge with out_ready=1.
REQ-028 Operand isolation:
- Stimulus: change a/b and hold in_valid=1 during CALC.
- Response: no second accept and no change to the result.
- The held request is accepted on the first edge after return to IDLE, and its own correct product follows.
REQ-029 Reset mid-operation:
- Stimulus: assert rst on the edge after step1.
- Response: next cycle shows IDLE, p=0, out_valid=0, in_ready=1; no stale out_valid appears afterwards.
REQ-030 Randomised back-to-back run:
- Stimulus: 1000 random operand pairs with random out_ready.
- Response: every p equals a*b, and products arrive in acceptance order with no loss or duplication.
